ptpv2_pbus_arbiter: RTL and testbench

//  Shares the apb-like register bus (pbus_*) of ptpv2_core_wrapper between N_REQ

---
 rtl/ptpv2_pbus_arbiter.sv | 152 +++++++++++++++
 tb/tb_ptpv2_pbus_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ptpv2_pbus_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share the ptpv2_core_wrapper pbus.
// It runs one setup/access transfer per grant and returns the result to the winner only.
module ptpv2_pbus_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  pbus_clk,
  input  logic                  pbus_rst_n,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ-1:0]      req_write_i,
  input  logic [32*N_REQ-1:0]   req_addr_i,
  input  logic [32*N_REQ-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]      req_ack_o,
  output logic [31:0]           req_rdata_o,
  output logic                  req_err_o,
  output logic                  busy_o,
  output logic [31:0]           pbus_addr_o,
  output logic                  pbus_write_o,
  output logic                  pbus_sel_o,
  output logic                  pbus_enable_o,
  output logic [31:0]           pbus_wdata_o,
  input  logic [31:0]           pbus_rdata_i,
  input  logic                  pbus_ready_i,
  input  logic                  pbus_slverr_i
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win_q, win_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        addr_d, wdata_d, rdata_d;
  logic               write_d, sel_d, enable_d, err_d, busy_d;
  logic [N_REQ-1:0]   ack_d;

  logic               found;
  logic [PW-1:0]      win_sel;
  logic [PW:0]        sum;

  // Search upward from the pointer with wrap; the first pending requester wins.
  always_comb begin
    found   = 1'b0;
    win_sel = '0;
    sum     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_REQ))
        sum = sum - (PW+1)'(N_REQ);
      if (!found && req_i[sum[PW-1:0]]) begin
        found   = 1'b1;
        win_sel = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    addr_d   = pbus_addr_o;
    write_d  = pbus_write_o;
    wdata_d  = pbus_wdata_o;
    sel_d    = 1'b0;
    enable_d = 1'b0;
    ack_d    = '0;
    rdata_d  = '0;
    err_d    = 1'b0;
    busy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SETUP;
          win_d   = win_sel;
          ptr_d   = (win_sel == PW'(N_REQ - 1)) ? '0 : win_sel + PW'(1);
          addr_d  = req_addr_i[32*win_sel +: 32];
          wdata_d = req_wdata_i[32*win_sel +: 32];
          write_d = req_write_i[win_sel];
          cnt_d   = '0;
          sel_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        state_d  = ACCESS;
        sel_d    = 1'b1;
        enable_d = 1'b1;
        busy_d   = 1'b1;
      end
      ACCESS: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        // Ready takes priority over a timeout expiring in the same cycle.
        if (pbus_ready_i) begin
          state_d = DONE;
          ack_d   = N_REQ'(1) << win_q;
          rdata_d = pbus_write_o ? 32'h0 : pbus_rdata_i;
          err_d   = pbus_slverr_i;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          state_d = DONE;
          ack_d   = N_REQ'(1) << win_q;
          err_d   = 1'b1;
        end else begin
          sel_d    = 1'b1;
          enable_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pbus_clk or negedge pbus_rst_n) begin
    if (!pbus_rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      cnt_q         <= '0;
      pbus_addr_o   <= '0;
      pbus_write_o  <= 1'b0;
      pbus_wdata_o  <= '0;
      pbus_sel_o    <= 1'b0;
      pbus_enable_o <= 1'b0;
      req_ack_o     <= '0;
      req_rdata_o   <= '0;
      req_err_o     <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      cnt_q         <= cnt_d;
      pbus_addr_o   <= addr_d;
      pbus_write_o  <= write_d;
      pbus_wdata_o  <= wdata_d;
      pbus_sel_o    <= sel_d;
      pbus_enable_o <= enable_d;
      req_ack_o     <= ack_d;
      req_rdata_o   <= rdata_d;
      req_err_o     <= err_d;
      busy_o        <= busy_d;
    end
  end

endmodule

// File: tb/tb_ptpv2_pbus_arbiter.sv
// Directed bench for ptpv2_pbus_arbiter with two requesters and a short timeout.
module tb_ptpv2_pbus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  req_write = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic [31:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  ptpv2_pbus_arbiter #(.N_REQ(2), .TIMEOUT(4)) dut (
    .pbus_clk      (clk),
    .pbus_rst_n    (rst_n),
    .req_i         (req),
    .req_write_i   (req_write),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_ack_o     (ack),
    .req_rdata_o   (rdata),
    .req_err_o     (err),
    .busy_o        (busy),
    .pbus_addr_o   (paddr),
    .pbus_write_o  (pwrite),
    .pbus_sel_o    (psel),
    .pbus_enable_o (penable),
    .pbus_wdata_o  (pwdata),
    .pbus_rdata_i  (prdata),
    .pbus_ready_i  (pready),
    .pbus_slverr_i (pslverr)
  );

  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1);
    req       = r;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    stepCycle();
    stepCycle();
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_sel", 32'(psel), 32'h0);
    checkOutput("rst_enable", 32'(penable), 32'h0);
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_addr", paddr, 32'h0);
    checkOutput("rst_write", 32'(pwrite), 32'h0);
    checkOutput("rst_wdata", pwdata, 32'h0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("idle_busy", 32'(busy), 32'h0);

    // Zero-wait write from requester 0
    pready = 1'b1;
    pslverr = 1'b0;
    applyStimulus(2'b01, 2'b01, 32'h0000_0010, 32'h0, 32'hA5A5_5A5A, 32'h0);
    stepCycle();
    checkOutput("wr_setup_sel", 32'(psel), 32'h1);
    checkOutput("wr_setup_en", 32'(penable), 32'h0);
    checkOutput("wr_setup_addr", paddr, 32'h0000_0010);
    checkOutput("wr_setup_write", 32'(pwrite), 32'h1);
    checkOutput("wr_setup_wdata", pwdata, 32'hA5A5_5A5A);
    checkOutput("wr_setup_busy", 32'(busy), 32'h1);
    stepCycle();
    checkOutput("wr_access_sel", 32'(psel), 32'h1);
    checkOutput("wr_access_en", 32'(penable), 32'h1);
    checkOutput("wr_access_ack", 32'(ack), 32'h0);
    stepCycle();
    checkOutput("wr_ack", 32'(ack), 32'h1);
    checkOutput("wr_err", 32'(err), 32'h0);
    checkOutput("wr_rdata", rdata, 32'h0);
    checkOutput("wr_done_sel", 32'(psel), 32'h0);
    checkOutput("wr_done_busy", 32'(busy), 32'h1);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    stepCycle();
    checkOutput("wr_after_ack", 32'(ack), 32'h0);
    checkOutput("wr_after_busy", 32'(busy), 32'h0);
    checkOutput("wr_addr_hold", paddr, 32'h0000_0010);

    // Read with three wait states; ready coincides with the timeout count
    pready = 1'b0;
    prdata = 32'hBAD0_BAD0;
    applyStimulus(2'b01, 2'b00, 32'h0000_0020, 32'h0, 32'h0, 32'h0);
    stepCycle();
    checkOutput("rd_setup_addr", paddr, 32'h0000_0020);
    checkOutput("rd_setup_write", 32'(pwrite), 32'h0);
    stepCycle();
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("rd_wait_en", 32'(penable), 32'h1);
    checkOutput("rd_wait_ack", 32'(ack), 32'h0);
    pready = 1'b1;
    prdata = 32'h1234_5678;
    stepCycle();
    checkOutput("rd_ack", 32'(ack), 32'h1);
    checkOutput("rd_rdata", rdata, 32'h1234_5678);
    checkOutput("rd_err", 32'(err), 32'h0);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    stepCycle();
    checkOutput("rd_rdata_clear", rdata, 32'h0);
    checkOutput("rd_ack_clear", 32'(ack), 32'h0);

    // Slave error on a read from requester 1, then a clean read
    pslverr = 1'b1;
    prdata = 32'hDEAD_BEEF;
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h0000_0030, 32'h0, 32'h0);
    stepCycle();
    checkOutput("se_setup_addr", paddr, 32'h0000_0030);
    stepCycle();
    stepCycle();
    checkOutput("se_ack", 32'(ack), 32'h2);
    checkOutput("se_err", 32'(err), 32'h1);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    pslverr = 1'b0;
    stepCycle();
    checkOutput("se_err_clear", 32'(err), 32'h0);
    prdata = 32'hCAFE_F00D;
    applyStimulus(2'b01, 2'b00, 32'h0000_0040, 32'h0, 32'h0, 32'h0);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("ok_ack", 32'(ack), 32'h1);
    checkOutput("ok_err", 32'(err), 32'h0);
    checkOutput("ok_rdata", rdata, 32'hCAFE_F00D);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    stepCycle();

    // Timeout: ready never arrives, ACCESS lasts exactly four cycles
    pready = 1'b0;
    prdata = 32'hFFFF_FFFF;
    applyStimulus(2'b10, 2'b10, 32'h0, 32'h0000_0050, 32'h0, 32'h1111_2222);
    stepCycle();
    stepCycle();
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("to_last_access_en", 32'(penable), 32'h1);
    checkOutput("to_last_access_ack", 32'(ack), 32'h0);
    stepCycle();
    checkOutput("to_ack", 32'(ack), 32'h2);
    checkOutput("to_err", 32'(err), 32'h1);
    checkOutput("to_rdata", rdata, 32'h0);
    checkOutput("to_done_en", 32'(penable), 32'h0);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    stepCycle();
    checkOutput("to_err_clear", 32'(err), 32'h0);

    // Contention: both requesters held, grants must alternate 0,1,0,1
    pready = 1'b1;
    applyStimulus(2'b11, 2'b00, 32'h0000_0100, 32'h0000_0200, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      checkOutput($sformatf("ct%0d_addr", k), paddr,
                  (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      stepCycle();
      stepCycle();
      checkOutput($sformatf("ct%0d_ack", k), 32'(ack),
                  (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k == 3)
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      stepCycle();
      checkOutput($sformatf("ct%0d_ack_clear", k), 32'(ack), 32'h0);
    end

    // Reset during ACCESS aborts the transfer without an ack
    pready = 1'b0;
    applyStimulus(2'b01, 2'b00, 32'h0000_0060, 32'h0, 32'h0, 32'h0);
    stepCycle();
    stepCycle();
    checkOutput("ra_access_en", 32'(penable), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("ra_sel", 32'(psel), 32'h0);
    checkOutput("ra_en", 32'(penable), 32'h0);
    checkOutput("ra_busy", 32'(busy), 32'h0);
    checkOutput("ra_addr", paddr, 32'h0);
    checkOutput("ra_ack", 32'(ack), 32'h0);
    applyStimulus(2'b10, 2'b00, 32'h0000_0060, 32'h0000_0070, 32'h0, 32'h0);
    pready = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("ra_hold_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("ra_grant_addr", paddr, 32'h0000_0070);
    checkOutput("ra_grant_sel", 32'(psel), 32'h1);
    stepCycle();
    stepCycle();
    checkOutput("ra_grant_ack", 32'(ack), 32'h2);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    stepCycle();
    checkOutput("ra_final_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
